instr_encoder: RTL
==================

# instr_encoder

Instruction encoder for the single-cycle MIPS datapath. It is the inverse of the control decoder: it takes symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake. It packs them into 32-bit MIPS instruction words, buffers them in a small FIFO, and streams them out with sequential word addresses. It feeds instruction-memory loaders and self-checking benches that drive the decoder.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0, address assigned to the first emitted word after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 ADDI, 8 ANDI, 9 J, 10 BEQ, 11 BNE, 12–15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  26  immediate. I-type uses [15:0]; J uses [25:0].
- instr_valid  out  1  head word available.
- instr_ready  in  1  consumer takes the head word.
- instr_word  out  32  encoded head word.
- instr_addr  out  32  byte address of the head word.
- err_illegal  out  1  sticky illegal-op flag (see Configuration).

## Operation
- Encoding is combinational from the req_* inputs.
- R-type (ops 0–4): {6'b000000, rs, rt, rd, 5'b0, func}.
  - func: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- I-type: {opcode, rs, rt, imm[15:0]}.
  - opcode: LW 100011, SW 101011, ADDI 001000, ANDI 001100, BEQ 000100, BNE 000101.
- J: {6'b000010, imm[25:0]}.
- Unused request fields are ignored: rd and imm for R-type; rd for I-type; rs, rt and rd for J.
- Push: on a clock edge with req_valid && req_ready, the encoded word is written at the write pointer; the write pointer and count advance.
- Pop: on a clock edge with instr_valid && instr_ready, the read pointer advances, count decrements, and the address counter adds 4.
- Pointers wrap modulo DEPTH. The address counter wraps modulo 2^32.
- req_ready = (count != DEPTH). A full FIFO refuses pushes even when a pop happens in the same cycle; there is no bypass.
- instr_valid = (count != 0). instr_word is the word at the read pointer. instr_addr is the address counter.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and both pointers advance.
- instr_word and instr_addr hold steady while instr_valid && !instr_ready.

## Timing
- Reset values:
  - Pointers and count 0.
  - req_ready 1, instr_valid 0, err_illegal 0.
  - instr_addr BASE_ADDR.
  - instr_word don't-care while instr_valid is 0.
- Latency: a request accepted at edge N into an empty FIFO gives instr_valid = 1 after edge N, with the word visible in the same cycle.
- Throughput: one word per cycle with instr_ready held high.
- Reset mid-stream: buffered words are discarded and the address counter returns to BASE_ADDR. No partial word is ever emitted.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined:
  - Illegal ops 12–15 are accepted (req_ready governs as usual) but not pushed.
  - err_illegal sets on the accepting edge and stays set until rst.
- ENC_ILLEGAL_CHECK_EN undefined:
  - Illegal ops encode as 32'h00000000 (NOP) and are pushed normally.
  - err_illegal is tied to 0.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 with instr_ready=1 -> next cycle instr_valid=1, instr_word=0x00221820, instr_addr=0x00000000.
- LW rs=29 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, then J imm=0x100 -> words 0x8FA80004, 0x1022FFFF, 0x08000100 at addresses 0x0, 0x4, 0x8.
- instr_ready=0, push 5 requests with DEPTH=4 -> req_ready low after the 4th; the 5th is held. Then instr_ready=1 -> all 5 emitted in order and addresses increment by 4.
- Full FIFO with req_valid=1 and instr_ready=1 in the same cycle -> one pop, no push, count 3. The following cycle the push is accepted.
- req_op=13 -> with ENC_ILLEGAL_CHECK_EN: nothing emitted and err_illegal=1, sticky. Without the macro: word 0x00000000 emitted and err_illegal=0.
- rst asserted asynchronously with 3 words buffered -> instr_valid=0, req_ready=1 and instr_addr=BASE_ADDR immediately, without waiting for clk.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs symbolic requests into 32-bit words, buffers them
// in a DEPTH-entry FIFO and streams them out with byte addresses. Optional macro: ENC_ILLEGAL_CHECK_EN.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [25:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic [31:0] instr_addr,
    output logic        err_illegal
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   enc_word;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        enc_word = 32'h0000_0000;
        case (req_op)
            4'd0:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100000};
            4'd1:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100010};
            4'd2:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100100};
            4'd3:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100101};
            4'd4:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b101010};
            4'd5:  enc_word = {6'b100011, req_rs, req_rt, req_imm[15:0]};
            4'd6:  enc_word = {6'b101011, req_rs, req_rt, req_imm[15:0]};
            4'd7:  enc_word = {6'b001000, req_rs, req_rt, req_imm[15:0]};
            4'd8:  enc_word = {6'b001100, req_rs, req_rt, req_imm[15:0]};
            4'd9:  enc_word = {6'b000010, req_imm};
            4'd10: enc_word = {6'b000100, req_rs, req_rt, req_imm[15:0]};
            4'd11: enc_word = {6'b000101, req_rs, req_rt, req_imm[15:0]};
            default: enc_word = 32'h0000_0000;
        endcase
    end

    // No bypass: a full FIFO refuses the request even if the head pops this cycle.
    assign req_ready   = (count_q != FULL_CNT);
    assign instr_valid = (count_q != '0);
    assign instr_word  = mem_q[rd_ptr_q];
    assign instr_addr  = addr_q;
    assign accept      = req_valid && req_ready;
    assign pop         = instr_valid && instr_ready;

`ifdef ENC_ILLEGAL_CHECK_EN
    logic illegal;
    logic err_q, err_d;

    assign illegal     = req_op[3] && req_op[2];
    assign push        = accept && !illegal;
    assign err_d       = err_q || (accept && illegal);
    assign err_illegal = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign push        = accept;
    assign err_illegal = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        addr_d   = pop ? addr_q + 32'd4 : addr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    // Storage carries data only; its contents are don't-care while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule
